// File: rtl/aes_decryption.sv
// Iterative AES-256 inverse cipher: one inverse round per clock, v/ready in, v/yumi out.
// Round keys are taken from a latched copy of the encryptor's key chain (rk0 in the MSBs).
module aes_decryption #(
    parameter int rounds_p          = 14,
    parameter int key_chain_width_p = (rounds_p + 1) * 128
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         v_i,
    output logic                         ready_o,
    input  logic [127:0]                 ciphertext,
    input  logic [key_chain_width_p-1:0] key_chain,
    output logic                         v_o,
    input  logic                         yumi_i,
    output logic [127:0]                 plaintext
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    fsm_t                         fsm_reg, fsm_next;
    logic [127:0]                 state_reg;
    logic [3:0]                   counter_reg;
    logic [key_chain_width_p-1:0] key_reg;
    logic [127:0]                 plaintext_reg;

    logic [127:0] isr, isb, ark, imc;
    logic [127:0] rk [0:rounds_p];

    // Entry 0x00 sits in the MSBs of the table, so index from the top.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'hff - x;
        return INV_SBOX[{r, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    genvar gi;

    generate
        for (gi = 0; gi <= rounds_p; gi++) begin : g_rk
            assign rk[gi] = key_reg[key_chain_width_p-1-128*gi -: 128];
        end

        // Byte gi is row gi%4, column gi/4; row r is rotated right by r.
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int R   = gi % 4;
            localparam int C   = gi / 4;
            localparam int SRC = 4 * ((C - R + 4) % 4) + R;
            assign isr[127-8*gi -: 8] = state_reg[127-8*SRC -: 8];
            assign isb[127-8*gi -: 8] = inv_sbox(isr[127-8*gi -: 8]);
        end

        for (gi = 0; gi < 4; gi++) begin : g_col
            assign imc[127-32*gi -: 32] = inv_mix_col(ark[127-32*gi -: 32]);
        end
    endgenerate

    // With counter at 0 this selects rk0 and ark is the final plaintext.
    assign ark = isb ^ rk[counter_reg];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE:    if (v_i) fsm_next = ROUND;
            ROUND:   if (counter_reg == 4'd0) fsm_next = DONE;
            DONE:    if (yumi_i) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (fsm_reg == IDLE);
        v_o     = (fsm_reg == DONE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg     <= '0;
            counter_reg   <= '0;
            key_reg       <= '0;
            plaintext_reg <= '0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (v_i) begin
                        key_reg     <= key_chain;
                        state_reg   <= ciphertext ^ key_chain[127:0];
                        counter_reg <= 4'(rounds_p - 1);
                    end
                end
                ROUND: begin
                    if (counter_reg != 4'd0) begin
                        state_reg   <= imc;
                        counter_reg <= counter_reg - 4'd1;
                    end else begin
                        plaintext_reg <= ark;
                    end
                end
                default: ;
            endcase
        end
    end

    assign plaintext = plaintext_reg;

endmodule

// File: tb/tb_aes_decryption.sv
// Scoreboard bench for aes_decryption: a forward AES-256 model produces ciphertexts,
// the monitor checks the decrypted output against the original plaintext.
module tb_aes_decryption;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          v_i;
    logic          ready_o;
    logic [127:0]  ciphertext;
    logic [1919:0] key_chain;
    logic          v_o;
    logic          yumi_i;
    logic [127:0]  plaintext;

    aes_decryption dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .v_i        (v_i),
        .ready_o    (ready_o),
        .ciphertext (ciphertext),
        .key_chain  (key_chain),
        .v_o        (v_o),
        .yumi_i     (yumi_i),
        .plaintext  (plaintext)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [127:0] pt;
        int           acc;
    } exp_t;

    exp_t       sb [$];
    int         rise_cyc [$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         yumi_mode = 1;
    logic       yumi_force = 1'b0;
    logic [7:0] sbox_tab [256];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (forward AES-256) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            b = inv;
            sbox_tab[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                          ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic logic [1919:0] model_expand(input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   tmp;
        logic [7:0]    rcon;
        logic [1919:0] kc;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < 8) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                tmp = w[i-1];
                if (i % 8 == 0) begin
                    tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                    rcon = gmul(rcon, 8'h02);
                end else if (i % 8 == 4) begin
                    tmp = sub_word(tmp);
                end
                w[i] = w[i-8] ^ tmp;
            end
            kc[1919-32*i -: 32] = w[i];
        end
        return kc;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [1919:0] kc);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk, res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int rnd = 0; rnd <= 14; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
                if (rnd < 14) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                        s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                    end
                end
            end
            rk = kc[1919-128*rnd -: 128];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- yumi driver ----------------
    initial begin
        yumi_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            case (yumi_mode)
                0:       yumi_i = 1'($urandom_range(0, 1));
                1:       yumi_i = 1'b1;
                default: yumi_i = yumi_force;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic prev_v = 1'b0;
        logic hs_prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!reset_n_i) begin
                prev_v  = 1'b0;
                hs_prev = 1'b0;
            end else begin
                if (hs_prev) begin
                    chk("post_yumi_v_o", 128'(v_o), 128'd0);
                    chk("post_yumi_ready_o", 128'(ready_o), 128'd1);
                end
                hs_prev = 1'b0;
                if (v_o) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got plaintext %h with no block pending", plaintext);
                    end else begin
                        if (!prev_v) begin
                            chk("latency", 128'(cyc - sb[0].acc), 128'd14);
                            rise_cyc.push_back(cyc);
                        end
                        chk("plaintext", plaintext, sb[0].pt);
                        chk("done_ready_o", 128'(ready_o), 128'd0);
                        if (yumi_i) begin
                            void'(sb.pop_front());
                            hs_prev = 1'b1;
                        end
                    end
                end else if (sb.size() > 0 && cyc >= sb[0].acc) begin
                    chk("busy_ready_o", 128'(ready_o), 128'd0);
                end
                prev_v = v_o;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [127:0] ct, input logic [1919:0] kc,
                        input logic [127:0] pt, input bit hold_v);
        int   n = 0;
        exp_t e;
        while (!ready_o && n < 200) begin
            tick();
            n++;
        end
        if (!ready_o) begin
            chk("send_ready_timeout", 128'(ready_o), 128'd1);
        end else begin
            ciphertext = ct;
            key_chain  = kc;
            v_i        = 1'b1;
            e.pt       = pt;
            e.acc      = cyc + 1;
            sb.push_back(e);
            tick();
            if (!hold_v) v_i = 1'b0;
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            key_chain  = ~key_chain;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 400) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 128'(sb.size()), 128'd0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0]  key_c3, key;
        logic [1919:0] kc_c3, kc;
        logic [127:0]  ct_c3, pt_c3, ct0, pt, lb_pt;
        int            base;

        reset_n_i  = 1'b0;
        v_i        = 1'b0;
        ciphertext = '0;
        key_chain  = '0;
        build_sbox();

        key_c3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        pt_c3  = 128'h00112233445566778899aabbccddeeff;
        kc_c3  = model_expand(key_c3);
        ct_c3  = 128'h8ea2b7ca516745bfeafc49904b496089;
        chk("model_rk14", kc_c3[127:0], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        chk("model_c3_encrypt", model_encrypt(pt_c3, kc_c3), ct_c3);

        // Reset state
        tick();
        chk("reset_ready_o", 128'(ready_o), 128'd1);
        chk("reset_v_o", 128'(v_o), 128'd0);
        chk("reset_plaintext", plaintext, 128'd0);
        tick();
        reset_n_i = 1'b1;
        tick();

        // FIPS-197 C.3
        yumi_mode = 1;
        send(ct_c3, kc_c3, pt_c3, 1'b0);
        drain();

        // Loopback of the forward model's ciphertext
        lb_pt = {32'haaaaaaaa, 96'b0};
        send(model_encrypt(lb_pt, kc_c3), kc_c3, lb_pt, 1'b0);
        drain();

        // Output backpressure with an ignored v_i pulse while DONE
        yumi_mode  = 2;
        yumi_force = 1'b0;
        send(ct_c3, kc_c3, pt_c3, 1'b0);
        for (int n = 0; n < 40 && !v_o; n++) tick();
        chk("bp_v_o_rise", 128'(v_o), 128'd1);
        for (int n = 0; n < 20; n++) begin
            if (n == 5) begin
                v_i        = 1'b1;
                ciphertext = {$urandom, $urandom, $urandom, $urandom};
            end
            if (n == 6) v_i = 1'b0;
            tick();
        end
        yumi_force = 1'b1;
        tick();
        yumi_force = 1'b0;
        tick();
        chk("bp_queue_empty", 128'(sb.size()), 128'd0);

        // Busy-input isolation
        yumi_mode = 1;
        send(ct_c3, kc_c3, pt_c3, 1'b0);
        repeat (3) tick();
        ciphertext = '1;
        key_chain  = '0;
        v_i        = 1'b1;
        repeat (5) tick();
        v_i = 1'b0;
        drain();
        repeat (20) tick();

        // Asynchronous reset mid-operation
        send(ct_c3, kc_c3, pt_c3, 1'b0);
        repeat (4) tick();
        #3;
        reset_n_i = 1'b0;
        #1;
        chk("midreset_v_o", 128'(v_o), 128'd0);
        chk("midreset_ready_o", 128'(ready_o), 128'd1);
        chk("midreset_plaintext", plaintext, 128'd0);
        sb.delete();
        repeat (2) @(posedge clk_i);
        #4;
        reset_n_i = 1'b1;
        tick();
        send(ct_c3, kc_c3, pt_c3, 1'b0);
        drain();

        // Back-to-back with v_i held high
        ct0  = model_encrypt(128'd0, kc_c3);
        base = rise_cyc.size();
        send(ct_c3, kc_c3, pt_c3, 1'b1);
        send(ct0, kc_c3, 128'd0, 1'b1);
        v_i = 1'b0;
        drain();
        tick();
        chk("b2b_outputs", 128'(rise_cyc.size() - base), 128'd2);
        if (rise_cyc.size() - base == 2)
            chk("b2b_spacing", 128'(rise_cyc[base+1] - rise_cyc[base]), 128'd16);

        // Randomized keys, plaintexts and backpressure
        yumi_mode = 0;
        for (int t = 0; t < 10; t++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            kc  = model_expand(key);
            send(model_encrypt(pt, kc), kc, pt, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        yumi_mode = 1;
        repeat (5) tick();
        chk("final_queue_empty", 128'(sb.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
